// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter; shares the open-collector clock/data lines with the keyboard receiver.
// Optional retry on NACK/timeout is compiled in with `define PS2_TX_RETRY_EN.
module ps2_host_tx #(
   parameter int CLK_FREQ_HZ    = 50_000_000,
   parameter int INHIBIT_CYCLES = 5_000,
   parameter int RTS_CYCLES     = 50,
   parameter int TIMEOUT_CYCLES = 750_000,
   parameter int MAX_RETRY      = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       busy,
   output logic       tx_done,
   output logic       tx_ack_ok,
   output logic       tx_error,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe
);

   // state       | meaning
   // S_IDLE      | lines released, ready for a command byte
   // S_INHIBIT   | clock held low to abort any device traffic
   // S_RTS       | clock and data (start bit) held low
   // S_SEND      | clock released; next data bit driven after each device fall
   // S_ACK       | stop released; device ACK sampled on the 11th fall
   // S_WAIT_IDLE | wait for both lines high before reporting
   // S_FINISH    | one-cycle tx_done with result flags
   typedef enum logic [2:0] {
      S_IDLE, S_INHIBIT, S_RTS, S_SEND, S_ACK, S_WAIT_IDLE, S_FINISH
   } state_t;

   localparam int CNT_MAX0 = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int CNT_MAX  = (RTS_CYCLES > CNT_MAX0) ? RTS_CYCLES : CNT_MAX0;
   localparam int CNT_W    = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] INH_LOAD = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] RTS_LOAD = CNT_W'(RTS_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           state, state_nxt;
   logic             clk_meta, clk_sync, clk_prev;
   logic             data_meta, data_sync;
   logic             fall, line_idle, accept, attempt_fail, retry_ok, on_bus;
   logic [9:0]       frame;
   logic [3:0]       bit_cnt;
   logic [CNT_W-1:0] timer;
   logic             ack_seen;
   logic [7:0]       load_byte;
   logic             clk_oe_nxt, data_oe_nxt, done_nxt, ack_ok_nxt, error_nxt, ready_nxt;
   logic             unused_cfg;

   assign unused_cfg = ^{CLK_FREQ_HZ, MAX_RETRY};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_meta  <= 1'b1;
         clk_sync  <= 1'b1;
         clk_prev  <= 1'b1;
         data_meta <= 1'b1;
         data_sync <= 1'b1;
      end else begin
         clk_meta  <= ps2_clk_in;
         clk_sync  <= clk_meta;
         clk_prev  <= clk_sync;
         data_meta <= ps2_data_in;
         data_sync <= data_meta;
      end
   end

   assign fall      = clk_prev & ~clk_sync;
   assign line_idle = clk_sync & data_sync;
   assign accept    = tx_valid & tx_ready;
   assign busy      = ~tx_ready;
   assign on_bus    = (state == S_SEND) || (state == S_ACK) || (state == S_WAIT_IDLE);

`ifdef PS2_TX_RETRY_EN
   localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   logic [RETRY_W-1:0] retry_cnt;
   logic [7:0]         byte_hold;

   assign retry_ok  = (retry_cnt < RETRY_W'(MAX_RETRY));
   assign load_byte = accept ? tx_data : byte_hold;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retry_cnt <= '0;
         byte_hold <= '0;
      end else if (accept) begin
         retry_cnt <= '0;
         byte_hold <= tx_data;
      end else if (attempt_fail && retry_ok) begin
         retry_cnt <= retry_cnt + RETRY_W'(1);
      end
   end
`else
   assign retry_ok  = 1'b0;
   assign load_byte = tx_data;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
         tx_done     <= 1'b0;
         tx_ack_ok   <= 1'b0;
         tx_error    <= 1'b0;
         tx_ready    <= 1'b1;
      end else begin
         state       <= state_nxt;
         ps2_clk_oe  <= clk_oe_nxt;
         ps2_data_oe <= data_oe_nxt;
         tx_done     <= done_nxt;
         tx_ack_ok   <= ack_ok_nxt;
         tx_error    <= error_nxt;
         tx_ready    <= ready_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      attempt_fail = 1'b0;
      unique case (state)
         S_IDLE:      if (accept) state_nxt = S_INHIBIT;
         S_INHIBIT:   if (timer == '0) state_nxt = S_RTS;
         S_RTS:       if (timer == '0) state_nxt = S_SEND;
         S_SEND: begin
            if (fall) begin
               if (bit_cnt == 4'd9) state_nxt = S_ACK;
            end else if (timer == '0) begin
               attempt_fail = 1'b1;
            end
         end
         S_ACK: begin
            if (fall) state_nxt = S_WAIT_IDLE;
            else if (timer == '0) attempt_fail = 1'b1;
         end
         S_WAIT_IDLE: begin
            if (line_idle) begin
               if (ack_seen) state_nxt = S_FINISH;
               else attempt_fail = 1'b1;
            end else if (timer == '0) begin
               attempt_fail = 1'b1;
            end
         end
         S_FINISH:    state_nxt = S_IDLE;
         default:     state_nxt = S_IDLE;
      endcase
      if (attempt_fail) state_nxt = retry_ok ? S_INHIBIT : S_FINISH;
   end

   // data_oe holds the start bit from RTS into SEND until the first device fall
   always_comb begin
      clk_oe_nxt  = (state_nxt == S_INHIBIT) || (state_nxt == S_RTS);
      data_oe_nxt = 1'b0;
      if (state_nxt == S_RTS)
         data_oe_nxt = 1'b1;
      else if ((state_nxt == S_SEND) || (state_nxt == S_ACK))
         data_oe_nxt = ((state == S_SEND) && fall) ? ~frame[0] : ps2_data_oe;
      done_nxt   = (state_nxt == S_FINISH);
      ack_ok_nxt = done_nxt & ~attempt_fail;
      error_nxt  = done_nxt & attempt_fail;
      ready_nxt  = (state_nxt == S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame    <= '0;
         bit_cnt  <= '0;
         ack_seen <= 1'b0;
      end else if ((state_nxt == S_INHIBIT) && (state != S_INHIBIT)) begin
         frame    <= {1'b1, ~^load_byte, load_byte};
         bit_cnt  <= '0;
         ack_seen <= 1'b0;
      end else if ((state == S_SEND) && fall) begin
         frame    <= {1'b1, frame[9:1]};
         bit_cnt  <= bit_cnt + 4'd1;
      end else if ((state == S_ACK) && fall) begin
         ack_seen <= ~data_sync;
      end
   end

   // single down-counter shared by inhibit, request-to-send and the bus timeout
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         timer <= '0;
      else if ((state_nxt == S_INHIBIT) && (state != S_INHIBIT))
         timer <= INH_LOAD;
      else if ((state == S_INHIBIT) && (state_nxt == S_RTS))
         timer <= RTS_LOAD;
      else if (((state == S_RTS) && (state_nxt == S_SEND)) || (on_bus && fall))
         timer <= TMO_LOAD;
      else if (timer != '0)
         timer <= timer - CNT_W'(1);
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain PS/2 device model, random command bytes, ACK/NACK/timeout/reset cases.
module tb_ps2_host_tx;
   localparam int INH  = 40;
   localparam int RTS  = 6;
   localparam int TMO  = 400;
   localparam int MAXR = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] tx_data = '0;
   logic       tx_valid = 1'b0;
   logic       tx_ready, busy, tx_done, tx_ack_ok, tx_error, ps2_clk_oe, ps2_data_oe;
   logic       dev_clk = 1'b1;
   logic       dev_data = 1'b1;
   logic       ps2_clk_line, ps2_data_line;

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   int inh_cnt  = 0;
   logic clk_oe_q = 1'b0;

   assign ps2_clk_line  = dev_clk & ~ps2_clk_oe;
   assign ps2_data_line = dev_data & ~ps2_data_oe;

   ps2_host_tx #(
      .CLK_FREQ_HZ(50_000_000), .INHIBIT_CYCLES(INH), .RTS_CYCLES(RTS),
      .TIMEOUT_CYCLES(TMO), .MAX_RETRY(MAXR)
   ) dut (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .busy(busy), .tx_done(tx_done), .tx_ack_ok(tx_ack_ok),
      .tx_error(tx_error), .ps2_clk_in(ps2_clk_line), .ps2_data_in(ps2_data_line),
      .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
   );

   always #10 clk = ~clk;

   always @(negedge clk) begin
      if (tx_done) done_cnt <= done_cnt + 1;
      if (ps2_clk_oe && !clk_oe_q) inh_cnt <= inh_cnt + 1;
      clk_oe_q <= ps2_clk_oe;
   end

   initial begin
      #(20 * 60000);
      $display("FAIL watchdog: observed no end of test, expected finish within 60000 cycles");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Device view of a frame, index 0 = start bit: start 0, data LSB first, odd parity, stop 1
   function automatic logic [10:0] frame_model(input logic [7:0] b);
      int ones = 0;
      for (int i = 0; i < 8; i++) if (b[i]) ones++;
      return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, b, 1'b0};
   endfunction

   task automatic host_phase(output int inh, output int rts, output bit rdy_bad, output bit ok);
      int n = 0;
      inh = 0; rts = 0; rdy_bad = 1'b0; ok = 1'b0;
      while (!ps2_clk_oe && n < TMO + 100) begin @(negedge clk); n++; end
      while (ps2_clk_oe && n < TMO + 200 + INH + RTS) begin
         if (ps2_data_oe) rts++; else inh++;
         if (tx_ready || !busy) rdy_bad = 1'b1;
         if (inh == 2) tx_data = ~tx_data;
         if (inh == 3) tx_valid = 1'b0;
         @(negedge clk); n++;
      end
      tx_valid = 1'b0;
      ok = !ps2_clk_oe && ps2_data_oe;
   endtask

   task automatic dev_frame(input int half, input bit nack, input int stop_after, output logic [10:0] got);
      got = '0;
      got[0] = ps2_data_line;
      for (int i = 1; i <= 11; i++) begin
         repeat (half) @(negedge clk);
         dev_clk = 1'b0;
         repeat (half) @(negedge clk);
         if (i <= 10) got[i] = ps2_data_line;
         dev_clk = 1'b1;
         if (i == 10) dev_data = nack;
         if (i == 11) dev_data = 1'b1;
         if (i == stop_after) begin dev_data = 1'b1; return; end
      end
   endtask

   task automatic send(input logic [7:0] b, input int n_nack, input int half, input bit dev_on,
                       input string tag, output logic [10:0] got);
      int attempts, base_done, base_inh, inh, rts, cyc;
      bit rdy_bad, ok, exp_ack;
`ifdef PS2_TX_RETRY_EN
      attempts = dev_on ? (((n_nack > MAXR) ? MAXR : n_nack) + 1) : (MAXR + 1);
      exp_ack  = dev_on && (n_nack <= MAXR);
`else
      attempts = 1;
      exp_ack  = dev_on && (n_nack == 0);
`endif
      got = '0;
      base_done = done_cnt;
      base_inh  = inh_cnt;
      @(negedge clk);
      check({tag, "_ready"}, tx_ready, 1);
      tx_data  = b;
      tx_valid = 1'b1;
      for (int a = 0; a < attempts; a++) begin
         host_phase(inh, rts, rdy_bad, ok);
         check({tag, "_inhibit_cycles"}, inh, INH);
         check({tag, "_rts_cycles"}, rts, RTS);
         check({tag, "_busy_during"}, rdy_bad, 0);
         check({tag, "_start_bit"}, ok, 1);
         if (!ok) return;
         if (dev_on) begin
            dev_frame(half, (a < n_nack), 0, got);
            check({tag, "_frame"}, got, frame_model(b));
         end
      end
      cyc = 0;
      while (!tx_done && cyc < TMO + 100) begin @(negedge clk); cyc++; end
      check({tag, "_done"}, tx_done, 1);
      if (!dev_on) check({tag, "_timeout_cycles"}, cyc, TMO);
      check({tag, "_ack_ok"}, tx_ack_ok, exp_ack);
      check({tag, "_error"}, tx_error, !exp_ack);
      @(negedge clk);
      check({tag, "_done_one_cycle"}, tx_done, 0);
      check({tag, "_ready_after"}, tx_ready, 1);
      check({tag, "_oe_after"}, {ps2_clk_oe, ps2_data_oe}, 0);
      repeat (2) @(negedge clk);
      check({tag, "_done_count"}, done_cnt - base_done, 1);
      check({tag, "_inhibit_phases"}, inh_cnt - base_inh, attempts);
   endtask

   initial begin
      logic [10:0] got;
      logic [7:0]  b;
      int inh, rts, n_nack, half;
      bit rdy_bad, ok;

      repeat (3) @(negedge clk);
      check("rst_ready", tx_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_flags", {tx_done, tx_ack_ok, tx_error}, 0);
      check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      send(8'hED, 0, 10, 1'b1, "ed_ack", got);
      check("ed_bits", got, 11'h7DA);
      send(8'h00, 0, 9, 1'b1, "par_00", got);
      check("par_00_parity", got[9], 1);
      send(8'h01, 0, 11, 1'b1, "par_01", got);
      check("par_01_parity", got[9], 0);
      send(8'hA5, 1, 10, 1'b1, "nack", got);
      send(8'h3C, 0, 10, 1'b0, "timeout", got);
      send(8'hFF, 0, 10, 1'b1, "ff_after_tmo", got);

      @(negedge clk);
      tx_data  = 8'h00;
      tx_valid = 1'b1;
      host_phase(inh, rts, rdy_bad, ok);
      check("rst_mid_start", ok, 1);
      dev_frame(10, 1'b0, 4, got);
      check("pre_rst_data_oe", ps2_data_oe, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
      check("mid_rst_ready", tx_ready, 1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      send(8'hF4, 0, 12, 1'b1, "f4_after_rst", got);

`ifdef PS2_TX_RETRY_EN
      send(8'hED, 2, 10, 1'b1, "retry_ack", got);
      send(8'h55, 3, 10, 1'b1, "retry_fail", got);
`endif

      for (int k = 0; k < 6; k++) begin
         b    = 8'($urandom);
         half = $urandom_range(14, 8);
`ifdef PS2_TX_RETRY_EN
         n_nack = $urandom_range(3, 0);
`else
         n_nack = $urandom_range(1, 0);
`endif
         send(b, n_nack, half, 1'b1, "rand", got);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
